// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: L1 I-cache miss refill from L2 with victim selection, replay pulse and full-cache flush sweep.
module icache_refill_ctrl #(
  parameter int N_WAY  = 4,
  parameter int TAG_W  = 20,
  parameter int IDX_W  = 6,
  parameter int LINE_W = 512,
  localparam int RR_W  = $clog2(N_WAY)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   lookup_valid_i,
  input  logic                   hit_i,
  input  logic [TAG_W-1:0]       tag_i,
  input  logic [IDX_W-1:0]       idx_i,
  input  logic [N_WAY-1:0]       valid_vec_i,
  input  logic                   flush_i,
  output logic                   l2_req_valid_o,
  input  logic                   l2_req_ready_i,
  output logic [TAG_W+IDX_W-1:0] l2_req_addr_o,
  input  logic                   l2_rsp_valid_i,
  input  logic [LINE_W-1:0]      l2_rsp_line_i,
  output logic                   l2_rsp_ready_o,
  output logic                   wr_en_o,
  output logic [N_WAY-1:0]       wr_way_o,
  output logic [IDX_W-1:0]       wr_idx_o,
  output logic [TAG_W-1:0]       wr_tag_o,
  output logic                   wr_valid_o,
  output logic [LINE_W-1:0]      wr_line_o,
  output logic                   busy_o,
  output logic                   replay_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_RSP, WRITE, REPLAY, FLUSH} state_e;
  state_e              state_q, state_d;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic                fp_q, fp_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_WAY-1:0]    way_q, way_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [N_WAY-1:0]    inv_way, rr_way;
  logic                found;
  assign rr_way = N_WAY'(1) << rr_q;
  assign busy_o = (state_q != IDLE) || fp_q;
  // lowest-index invalid way wins; round-robin only when the set is full
  always_comb begin
    inv_way = '0;
    found   = 1'b0;
    for (int i = 0; i < N_WAY; i++)
      if (!valid_vec_i[i] && !found) begin
        inv_way[i] = 1'b1;
        found      = 1'b1;
      end
  end
  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    fp_d           = fp_q | flush_i;
    cnt_d          = cnt_q;
    tag_d          = tag_q;
    idx_d          = idx_q;
    way_d          = way_q;
    line_d         = line_q;
    l2_req_valid_o = 1'b0;
    l2_req_addr_o  = '0;
    l2_rsp_ready_o = 1'b0;
    wr_en_o        = 1'b0;
    wr_way_o       = '0;
    wr_idx_o       = '0;
    wr_tag_o       = '0;
    wr_valid_o     = 1'b0;
    wr_line_o      = '0;
    replay_o       = 1'b0;
    case (state_q)
      IDLE:
        if (fp_q || flush_i) state_d = FLUSH;
        else if (lookup_valid_i && !hit_i) begin
          tag_d   = tag_i;
          idx_d   = idx_i;
          way_d   = found ? inv_way : rr_way;
          rr_d    = found ? rr_q : rr_q + 1'b1;
          state_d = REQ;
        end
      REQ: begin
        l2_req_valid_o = 1'b1;
        l2_req_addr_o  = {tag_q, idx_q};
        state_d        = l2_req_ready_i ? WAIT_RSP : REQ;
      end
      WAIT_RSP: begin
        l2_rsp_ready_o = 1'b1;
        line_d         = l2_rsp_valid_i ? l2_rsp_line_i : line_q;
        state_d        = l2_rsp_valid_i ? WRITE : WAIT_RSP;
      end
      WRITE: begin
        wr_en_o    = 1'b1;
        wr_way_o   = way_q;
        wr_idx_o   = idx_q;
        wr_tag_o   = tag_q;
        wr_valid_o = 1'b1;
        wr_line_o  = line_q;
        state_d    = REPLAY;
      end
      REPLAY: begin
        replay_o = 1'b1;
        state_d  = IDLE;
      end
      FLUSH: begin
        wr_en_o  = 1'b1;
        wr_way_o = '1;
        wr_idx_o = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = IDLE;
          fp_d    = 1'b0;
          rr_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      fp_q    <= 1'b0;
      cnt_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      way_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      fp_q    <= fp_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
      line_q  <= line_d;
    end
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: vector table, directed corner sequences and randomized misses/flushes against a transaction-level model.
module tb_icache_refill_ctrl;
  localparam int N_WAY = 4, TAG_W = 20, IDX_W = 6, LINE_W = 512, AW = TAG_W + IDX_W;
  localparam logic [LINE_W-1:0] LINE_A = {16{32'hC0DE_5A11}};
  logic              clk, rst, lookup_valid, hit, flush, req_ready, rsp_valid;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [N_WAY-1:0]  valid_vec;
  logic [LINE_W-1:0] rsp_line;
  logic              req_valid, rsp_ready, wr_en, wr_valid, busy, replay;
  logic [AW-1:0]     req_addr;
  logic [N_WAY-1:0]  wr_way;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic [LINE_W-1:0] wr_line;
  int nvec = 0, nerr = 0, rr_m = 0;

  icache_refill_ctrl dut (
    .clk_i(clk), .rst_i(rst), .lookup_valid_i(lookup_valid), .hit_i(hit), .tag_i(tag), .idx_i(idx),
    .valid_vec_i(valid_vec), .flush_i(flush), .l2_req_valid_o(req_valid), .l2_req_ready_i(req_ready),
    .l2_req_addr_o(req_addr), .l2_rsp_valid_i(rsp_valid), .l2_rsp_line_i(rsp_line), .l2_rsp_ready_o(rsp_ready),
    .wr_en_o(wr_en), .wr_way_o(wr_way), .wr_idx_o(wr_idx), .wr_tag_o(wr_tag), .wr_valid_o(wr_valid),
    .wr_line_o(wr_line), .busy_o(busy), .replay_o(replay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic lv, ht;
    logic [TAG_W-1:0] tg;
    logic [IDX_W-1:0] ix;
    logic [N_WAY-1:0] vv;
    logic rdy, rv;
    logic e_busy, e_reqv;
    logic [AW-1:0] e_addr;
    logic e_rspr, e_wen;
    logic [N_WAY-1:0] e_way;
    logic e_wval, e_rep;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pick_victim(input logic [N_WAY-1:0] vv, output logic [N_WAY-1:0] ew);
    for (int i = 0; i < N_WAY; i++)
      if (!vv[i]) begin
        ew = N_WAY'(1) << i;
        return;
      end
    ew = N_WAY'(1) << (rr_m % N_WAY);
    rr_m++;
  endtask

  task automatic idle_inputs();
    lookup_valid = 0; hit = 0; flush = 0; req_ready = 0; rsp_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tag = '0; idx = '0; valid_vec = '0; rsp_line = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    rr_m = 0;
  endtask

  // Expects a full sweep starting at most a few cycles from now; optionally re-pulses flush mid-sweep.
  task automatic sweep(input bit repulse);
    @(negedge clk);
    flush = 0; lookup_valid = 0;
    for (int w = 0; w < 4 && !wr_en; w++) begin
      chk("busy_pre_flush", busy, 1);
      @(negedge clk);
    end
    for (int k = 0; k < 64; k++) begin
      chk("flush_wr_en", wr_en, 1);
      chk("flush_way", wr_way, 4'hF);
      chk("flush_valid", wr_valid, 0);
      chk("flush_idx", wr_idx, k);
      chk("flush_busy", busy, 1);
      flush = repulse && k == 10;
      @(negedge clk);
    end
    flush = 0;
    chk("post_flush_busy", busy, 0);
    chk("post_flush_wr_en", wr_en, 0);
    chk("post_flush_req", req_valid, 0);
    rr_m = 0;
  endtask

  // One miss: L2 ready withheld for rdly request cycles, response withheld for vdly wait cycles.
  task automatic do_miss(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] ix, input logic [N_WAY-1:0] vv,
                         input int rdly, input int vdly, input bit fl);
    logic [N_WAY-1:0] ew;
    logic [LINE_W-1:0] good;
    int reqs, rsps, wrs, rep_at;
    bit flushed;
    pick_victim(vv, ew);
    good = {16{$urandom}};
    lookup_valid = 1; hit = 0; tag = t; idx = ix; valid_vec = vv;
    reqs = 0; rsps = 0; wrs = 0; rep_at = 0; flushed = 0;
    for (int c = 1; c <= 40 && rep_at == 0; c++) begin
      @(negedge clk);
      lookup_valid = 0; flush = 0;
      chk("miss_busy", busy, 1);
      if (c == 1) chk("req_first_cycle", req_valid, 1);
      if (req_valid) begin
        chk("req_addr", req_addr, {t, ix});
        reqs++;
      end
      req_ready = req_valid && reqs > rdly;
      if (rsp_ready) begin
        rsps++;
        if (fl && !flushed) begin
          flush = 1;
          flushed = 1;
        end
      end
      rsp_valid = rsp_ready ? (rsps > vdly) : 1'($urandom_range(1, 0));
      rsp_line = rsp_ready ? good : ~good;
      if (wr_en) begin
        wrs++;
        chk("wr_way", wr_way, ew);
        chk("wr_idx", wr_idx, ix);
        chk("wr_tag", wr_tag, t);
        chk("wr_valid", wr_valid, 1);
        chk("wr_line", wr_line, good);
      end
      if (replay) rep_at = c;
    end
    idle_inputs();
    chk("write_count", wrs, 1);
    chk("replay_cycle", rep_at, 4 + rdly + vdly);
    if (fl) sweep(0);
    else begin
      @(negedge clk);
      chk("busy_after_replay", busy, 0);
      chk("replay_one_cycle", replay, 0);
      chk("wr_after_replay", wr_en, 0);
    end
  endtask

  initial begin
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_way", wr_way, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_tag", wr_tag, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_line", wr_line, 0);
    chk("rst_replay", replay, 0);

    //           lv ht tag        idx    vv    rdy rv  busy reqv addr                 rspr wen way   wval rep
    tbl[0] = '{1, 1, 20'h0,     6'd5,  4'hF, 0, 0,  0, 0, 26'h0,                0, 0, 4'h0, 0, 0};
    tbl[1] = '{0, 0, 20'h0,     6'd0,  4'h0, 0, 1,  0, 0, 26'h0,                0, 0, 4'h0, 0, 0};
    tbl[2] = '{1, 0, 20'h12345, 6'h0A, 4'h5, 1, 1,  1, 1, {20'h12345, 6'h0A},  0, 0, 4'h0, 0, 0};
    tbl[3] = '{0, 0, 20'h0,     6'd0,  4'h0, 1, 1,  1, 0, 26'h0,                1, 0, 4'h0, 0, 0};
    tbl[4] = '{0, 0, 20'h0,     6'd0,  4'h0, 0, 1,  1, 0, 26'h0,                0, 1, 4'h2, 1, 0};
    tbl[5] = '{0, 0, 20'h0,     6'd0,  4'h0, 0, 0,  1, 0, 26'h0,                0, 0, 4'h0, 0, 1};
    tbl[6] = '{0, 0, 20'h0,     6'd0,  4'h0, 0, 1,  0, 0, 26'h0,                0, 0, 4'h0, 0, 0};
    tbl[7] = '{0, 0, 20'h0,     6'd0,  4'h0, 0, 0,  0, 0, 26'h0,                0, 0, 4'h0, 0, 0};
    rsp_line = LINE_A;
    for (int i = 0; i < 8; i++) begin
      lookup_valid = tbl[i].lv; hit = tbl[i].ht; tag = tbl[i].tg; idx = tbl[i].ix;
      valid_vec = tbl[i].vv; req_ready = tbl[i].rdy; rsp_valid = tbl[i].rv;
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_req_valid", i), req_valid, tbl[i].e_reqv);
      chk($sformatf("v%0d_req_addr", i), req_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_rsp_ready", i), rsp_ready, tbl[i].e_rspr);
      chk($sformatf("v%0d_wr_en", i), wr_en, tbl[i].e_wen);
      chk($sformatf("v%0d_wr_way", i), wr_way, tbl[i].e_way);
      chk($sformatf("v%0d_wr_valid", i), wr_valid, tbl[i].e_wval);
      chk($sformatf("v%0d_wr_idx", i), wr_idx, tbl[i].e_wen ? 6'h0A : 6'h0);
      chk($sformatf("v%0d_wr_tag", i), wr_tag, tbl[i].e_wen ? 20'h12345 : 20'h0);
      chk($sformatf("v%0d_wr_line", i), wr_line, tbl[i].e_wen ? LINE_A : '0);
      chk($sformatf("v%0d_replay", i), replay, tbl[i].e_rep);
    end
    idle_inputs();

    do_reset();
    for (int i = 0; i < 5; i++) do_miss(20'(i * 7 + 3), 6'(i + 1), 4'hF, 0, 0, 0);
    do_miss(20'hABCDE, 6'h3F, 4'hF, 3, 3, 0);
    do_miss(20'h0F0F0, 6'h11, 4'hB, 1, 2, 1);

    // reset while waiting for L2: the late response must not be written
    lookup_valid = 1; hit = 0; tag = 20'h55555; idx = 6'h22; valid_vec = 4'h0;
    @(negedge clk);
    lookup_valid = 0; req_ready = 1;
    @(negedge clk);
    chk("rst_seq_in_wait", rsp_ready, 1);
    req_ready = 0; rst = 1;
    @(negedge clk);
    rst = 0; rr_m = 0;
    chk("rst_seq_busy", busy, 0);
    chk("rst_seq_rsp_ready", rsp_ready, 0);
    chk("rst_seq_req_valid", req_valid, 0);
    rsp_valid = 1; rsp_line = ~LINE_A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_seq_no_write", wr_en, 0);
      chk("rst_seq_no_replay", replay, 0);
      chk("rst_seq_idle", busy, 0);
    end
    idle_inputs();

    // flush and miss in the same cycle: flush wins, miss dropped, mid-sweep flush ignored
    lookup_valid = 1; hit = 0; tag = 20'h77777; idx = 6'h05; valid_vec = 4'hF; flush = 1;
    sweep(1);

    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(9, 0);
      if (r < 2) begin
        lookup_valid = 1; hit = 1; tag = 20'($urandom); idx = 6'($urandom);
        @(negedge clk);
        lookup_valid = 0; hit = 0;
        chk("rand_hit_busy", busy, 0);
        chk("rand_hit_req", req_valid, 0);
      end else if (r == 2) begin
        flush = 1;
        sweep(0);
      end else begin
        logic [N_WAY-1:0] vv;
        vv = ($urandom_range(1, 0) == 1) ? 4'hF : 4'($urandom);
        do_miss(20'($urandom), 6'($urandom), vv, $urandom_range(3, 0), $urandom_range(3, 0), r == 3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
